// File: rtl/csa_accum_if.sv
// csa_accum_if: operand/result handshake bundle for csa_accum; out_ovf exists only with CSA_ACCUM_OVF_EN
interface csa_accum_if #(parameter int DW = 8);
  logic in_valid, in_ready, in_last, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
`ifdef CSA_ACCUM_OVF_EN
  logic out_ovf;
  modport slave(input in_valid, in_data, in_last, out_ready, output in_ready, out_valid, out_data, out_ovf);
  modport master(output in_valid, in_data, in_last, out_ready, input in_ready, out_valid, out_data, out_ovf);
`else
  modport slave(input in_valid, in_data, in_last, out_ready, output in_ready, out_valid, out_data);
  modport master(output in_valid, in_data, in_last, out_ready, input in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/csa_accum.sv
// csa_accum: carry-save frame accumulator resolved CW bits per cycle; CSA_ACCUM_OVF_EN adds sticky out_ovf
module csa_accum #(
  parameter int DW = 8,
  parameter int CW = 4
) (
  input logic clk,
  input logic rst,
  csa_accum_if.slave bus
);
  localparam int NCH = DW / CW;
  localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {ACCUM, RESOLVE, DONE} state_t;
  state_t state_q;
  logic [DW-1:0] s_q, c_q, r_q, s_d, c_d;
  logic [IW-1:0] k_q;
  logic cy_q, last_k;
  logic [CW:0] sum_w;
  assign s_d = s_q ^ c_q ^ bus.in_data;
  assign c_d = {(s_q[DW-2:0] & c_q[DW-2:0]) | (s_q[DW-2:0] & bus.in_data[DW-2:0]) | (c_q[DW-2:0] & bus.in_data[DW-2:0]), 1'b0};
  assign last_k = k_q == IW'(NCH - 1);
  // chunk 0 never takes the stale inter-chunk carry
  assign sum_w = {1'b0, s_q[k_q*CW +: CW]} + {1'b0, c_q[k_q*CW +: CW]} + {{CW{1'b0}}, k_q != '0 && cy_q};
  assign bus.in_ready = state_q == ACCUM;
  assign bus.out_valid = state_q == DONE;
  assign bus.out_data = r_q;
`ifdef CSA_ACCUM_OVF_EN
  logic ovf_q, lost;
  assign lost = (s_q[DW-1] & c_q[DW-1]) | (s_q[DW-1] & bus.in_data[DW-1]) | (c_q[DW-1] & bus.in_data[DW-1]);
  assign bus.out_ovf = ovf_q;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      s_q <= '0;
      c_q <= '0;
      r_q <= '0;
      k_q <= '0;
      cy_q <= 1'b0;
`ifdef CSA_ACCUM_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ACCUM: if (bus.in_valid) begin
          s_q <= s_d;
          c_q <= c_d;
`ifdef CSA_ACCUM_OVF_EN
          ovf_q <= ovf_q | lost;
`endif
          if (bus.in_last) state_q <= RESOLVE;
        end
        RESOLVE: begin
          r_q[k_q*CW +: CW] <= sum_w[CW-1:0];
          cy_q <= sum_w[CW];
          k_q <= last_k ? '0 : k_q + 1'b1;
`ifdef CSA_ACCUM_OVF_EN
          ovf_q <= ovf_q | (last_k & sum_w[CW]);
`endif
          if (last_k) state_q <= DONE;
        end
        DONE: if (bus.out_ready) begin
          s_q <= '0;
          c_q <= '0;
          k_q <= '0;
`ifdef CSA_ACCUM_OVF_EN
          ovf_q <= 1'b0;
`endif
          state_q <= ACCUM;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end
endmodule

// File: doc/csa_accum.md
CSA_ACCUM -- requirements
Module: csa_accum

Interface
REQ-001 SHALL have parameter DW, default 8, meaning operand/result width in bits (8,16,32,64,128,...).
REQ-002 SHALL have parameter CW, default 4, meaning carry-propagate chunk width resolved per cycle; DW SHALL be an integer multiple of CW.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, operand valid.
REQ-006 SHALL have port in_ready, output, 1, operand accepted when in_valid & in_ready at a clock edge.
REQ-007 SHALL have port in_data, input, DW, unsigned operand.
REQ-008 SHALL have port in_last, input, 1, marks final operand of a frame.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, result consumed when out_valid & out_ready at a clock edge.
REQ-011 SHALL have port out_data, output, DW, frame sum modulo 2^DW.
REQ-012 SHALL have port out_ovf, output, 1, present only with CSA_ACCUM_OVF_EN: true sum >= 2^DW.

Function
REQ-013 SHALL hold a redundant accumulator: sum register S and pre-shifted carry register C, both DW bits.
REQ-014 On each accepted operand x: S <= S^C^x; C <= {maj(S,C,x)[DW-2:0], 0}; the maj bit DW-1 is the lost carry.
REQ-015 States: ACCUM, RESOLVE, DONE.
REQ-016 ACCUM: in_ready=1, out_valid=0; an accepted operand with in_last=1 moves to RESOLVE at that edge, with the operand included.
REQ-017 RESOLVE: in_ready=0; for NCH=DW/CW cycles, chunk k (LSB first) computes S[k]+C[k]+cin, writes CW bits into the result register; the carry feeds chunk k+1; cin=0 for chunk 0.
REQ-018 After the NCH-th resolve edge the block SHALL enter DONE; last accepted at edge E0 gives out_valid=1 from edge E0+NCH.
REQ-019 DONE: out_valid=1, in_ready=0; out_data (and out_ovf) SHALL stay stable until the out_ready handshake.
REQ-020 On the DONE handshake edge S, C, the ovf flag and the chunk index SHALL clear; the state returns to ACCUM.
REQ-021 The final carry-out of chunk NCH-1 SHALL be discarded from out_data (modulo 2^DW).
REQ-022 A frame SHALL contain at least one operand; a single-operand frame resolves to that operand.
REQ-023 in_data/in_last SHALL be ignored whenever in_ready=0.
REQ-024 out_data SHALL hold its last value outside DONE; it is not required to be meaningful there.

Reset
REQ-025 rst=1 at an edge SHALL force ACCUM, S=0, C=0, result=0, chunk index=0, ovf=0, in_ready=1 (after the edge), and out_valid=0, from any state including mid-RESOLVE and DONE; rst has priority over all handshakes.

Configuration
REQ-026 Macro CSA_ACCUM_OVF_EN defined: a sticky ovf bit SHALL be set by any nonzero lost carry (REQ-014) or by the final resolve carry-out (REQ-021); it is output as out_ovf and cleared per REQ-020/REQ-025.
REQ-027 Macro undefined: the out_ovf port and all ovf logic SHALL be absent; all other behaviour is identical.

Verification (DW=8, CW=4, NCH=2 unless stated)
REQ-028 Frame 0x0F, 0x01, 0x10(last), out_ready=1 -> out_valid two edges after the last accept, out_data=0x20, out_ovf=0.
REQ-029 Frame 0xFF, 0x02(last), macro defined -> out_data=0x01, out_ovf=1; the next frame 0x05(last) -> out_data=0x05, out_ovf=0.
REQ-030 Frame 0x80, 0x80, 0x80(last) -> lost carry sets ovf, out_data=0x80, out_ovf=1.
REQ-031 out_ready=0 for 5 cycles in DONE -> out_valid and out_data held, in_ready=0, in_valid pulses ignored; result accepted on out_ready=1.
REQ-032 rst asserted during the first RESOLVE cycle -> next cycle in_ready=1, out_valid=0; frame 0x03(last) then yields 0x03.
REQ-033 DW=32, CW=32 -> NCH=1; frame 0xFFFFFFFF, 0x00000001(last) -> out_data=0, out_ovf=1, out_valid one edge after the last accept.
